// File: rtl/voxel_raycaster_pkg.sv
// Shared voxel types: block coordinates, block ids, cube faces and the raycaster FSM states.
package voxel_raycaster_pkg;

    localparam int POS_W       = 8;
    localparam int CHUNK_WIDTH = 40;

    // Element [0] is x, [1] is y, [2] is z; each component is two's-complement.
    typedef logic [2:0][POS_W-1:0] BlockPos;
    typedef logic [7:0]            BlockType;
    localparam BlockType BLOCK_AIR = 8'd0;

    typedef enum logic [2:0] {
        FACE_NONE = 3'd0,
        FACE_XP   = 3'd1,
        FACE_XN   = 3'd2,
        FACE_YP   = 3'd3,
        FACE_YN   = 3'd4,
        FACE_ZP   = 3'd5,
        FACE_ZN   = 3'd6
    } Face;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        EVAL  = 2'd2
    } rc_state_e;

    // A step towards +axis enters the new voxel through its negative face, and vice versa.
    function automatic Face entry_face(input logic [1:0] axis, input logic neg);
        Face f;
        case (axis)
            2'd0:    f = neg ? FACE_XP : FACE_XN;
            2'd1:    f = neg ? FACE_YP : FACE_YN;
            2'd2:    f = neg ? FACE_ZP : FACE_ZN;
            default: f = FACE_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/voxel_raycaster_if.sv
// Ray request, chunk lookup and result bundle of the voxel raycaster.
interface voxel_raycaster_if
    import voxel_raycaster_pkg::*;
#(
    parameter int T_WIDTH = 16
);
    logic                    start_valid;
    logic                    start_ready;
    BlockPos                 origin;
    logic [2:0]              step_neg;
    logic [2:0][T_WIDTH-1:0] tmax_init;
    logic [2:0][T_WIDTH-1:0] tdelta;
    BlockPos                 query_addr;
    logic                    query_en;
    BlockType                query_block;
    logic                    query_valid;
    logic                    done;
    logic                    hit;
    BlockPos                 hit_pos;
    BlockType                hit_block;
    Face                     hit_face;

    modport slave (
        input  start_valid, origin, step_neg, tmax_init, tdelta, query_block, query_valid,
        output start_ready, query_addr, query_en, done, hit, hit_pos, hit_block, hit_face
    );

    modport master (
        output start_valid, origin, step_neg, tmax_init, tdelta, query_block, query_valid,
        input  start_ready, query_addr, query_en, done, hit, hit_pos, hit_block, hit_face
    );
endinterface

// File: rtl/voxel_raycaster_axis_select.sv
// Picks the axis whose tmax is smallest; ties resolve x before y before z.
module raycast_axis_select #(
    parameter int T_WIDTH = 16
) (
    input  logic [T_WIDTH-1:0] t_x,
    input  logic [T_WIDTH-1:0] t_y,
    input  logic [T_WIDTH-1:0] t_z,
    output logic [1:0]         axis
);
    // Ordered comparison so that equal values fall to the lower axis.
    always_comb begin
        axis = 2'd2;
        if ((t_x <= t_y) && (t_x <= t_z)) begin
            axis = 2'd0;
        end else if (t_y <= t_z) begin
            axis = 2'd1;
        end else begin
            axis = 2'd2;
        end
    end
endmodule

// File: rtl/voxel_raycaster.sv
// Voxel DDA raycaster: one chunk lookup per voxel until a solid block, the chunk edge or the
// step limit ends the ray. Define RAYCAST_FACE_EN to report the entry face of a hit.
module voxel_raycaster
    import voxel_raycaster_pkg::*;
#(
    parameter int MAX_STEPS = 64,
    parameter int T_WIDTH   = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    voxel_raycaster_if.slave rif
);
    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam logic signed [POS_W-1:0] BOUND_HI = POS_W'(CHUNK_WIDTH);
    localparam logic signed [POS_W-1:0] BOUND_LO = POS_W'(-CHUNK_WIDTH);
    localparam logic [POS_W-1:0]        ONE_POS  = POS_W'(1);

    rc_state_e               state_r, next_state_s;
    BlockPos                 pos_r, hit_pos_r;
    logic [2:0]              step_neg_r;
    logic [2:0][T_WIDTH-1:0] tmax_r, tdelta_r;
    logic [CNT_W-1:0]        cnt_r;
    BlockType                block_r, hit_block_r;
    logic                    start_ready_r, query_en_r, done_r, hit_r;
    logic [1:0]              axis_s;
    logic [POS_W-1:0]        stepped_s;
    logic [T_WIDTH:0]        tsum_s;
    logic [T_WIDTH-1:0]      tnext_s;
    logic                    accept_s, is_hit_s, oob_s, step_go_s;

    raycast_axis_select #(.T_WIDTH(T_WIDTH)) u_axis_select (
        .t_x  (tmax_r[0]),
        .t_y  (tmax_r[1]),
        .t_z  (tmax_r[2]),
        .axis (axis_s)
    );

    // Next-state decision plus the candidate step along the nearest boundary.
    always_comb begin
        next_state_s = state_r;
        accept_s     = rif.start_valid && start_ready_r;
        is_hit_s     = (block_r != BLOCK_AIR);
        stepped_s    = step_neg_r[axis_s] ? (pos_r[axis_s] - ONE_POS) : (pos_r[axis_s] + ONE_POS);
        oob_s        = ($signed(stepped_s) >= BOUND_HI) || ($signed(stepped_s) < BOUND_LO);
        tsum_s       = {1'b0, tmax_r[axis_s]} + {1'b0, tdelta_r[axis_s]};
        tnext_s      = tsum_s[T_WIDTH] ? {T_WIDTH{1'b1}} : tsum_s[T_WIDTH-1:0];
        case (state_r)
            IDLE:    next_state_s = accept_s ? QUERY : IDLE;
            QUERY:   next_state_s = (query_en_r && rif.query_valid) ? EVAL : QUERY;
            EVAL: begin
                if (is_hit_s || (cnt_r == CNT_W'(MAX_STEPS)) || oob_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = QUERY;
                end
            end
            default: next_state_s = IDLE;
        endcase
        step_go_s = (state_r == EVAL) && (next_state_s == QUERY);
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ray datapath and registered handshake/result outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pos_r         <= '0;
            step_neg_r    <= 3'b000;
            tmax_r        <= '0;
            tdelta_r      <= '0;
            cnt_r         <= '0;
            block_r       <= BLOCK_AIR;
            start_ready_r <= 1'b1;
            query_en_r    <= 1'b0;
            done_r        <= 1'b0;
            hit_r         <= 1'b0;
            hit_pos_r     <= '0;
            hit_block_r   <= BLOCK_AIR;
        end else begin
            start_ready_r <= (next_state_s == IDLE);
            query_en_r    <= (next_state_s == QUERY);
            done_r        <= (state_r == EVAL) && (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        pos_r      <= rif.origin;
                        step_neg_r <= rif.step_neg;
                        tmax_r     <= rif.tmax_init;
                        tdelta_r   <= rif.tdelta;
                        cnt_r      <= '0;
                    end
                end
                QUERY: begin
                    if (query_en_r && rif.query_valid) begin
                        block_r <= rif.query_block;
                    end
                end
                EVAL: begin
                    if (step_go_s) begin
                        pos_r[axis_s]  <= stepped_s;
                        tmax_r[axis_s] <= tnext_s;
                        cnt_r          <= cnt_r + CNT_W'(1);
                    end else begin
                        hit_r       <= is_hit_s;
                        hit_pos_r   <= pos_r;
                        hit_block_r <= block_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RAYCAST_FACE_EN
    Face last_face_r, hit_face_r;

    // Track the face crossed by the latest step and publish it when the ray ends.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_face_r <= FACE_NONE;
            hit_face_r  <= FACE_NONE;
        end else if (accept_s) begin
            last_face_r <= FACE_NONE;
        end else if (step_go_s) begin
            last_face_r <= entry_face(axis_s, step_neg_r[axis_s]);
        end else if (state_r == EVAL) begin
            hit_face_r <= is_hit_s ? last_face_r : FACE_NONE;
        end
    end

    assign rif.hit_face = hit_face_r;
`else
    assign rif.hit_face = FACE_NONE;
`endif

    assign rif.start_ready = start_ready_r;
    assign rif.query_en    = query_en_r;
    assign rif.query_addr  = pos_r;
    assign rif.done        = done_r;
    assign rif.hit         = hit_r;
    assign rif.hit_pos     = hit_pos_r;
    assign rif.hit_block   = hit_block_r;

endmodule

// File: doc/voxel_raycaster.md
VOXEL_RAYCASTER -- requirements
Module: voxel_raycaster

Interface
REQ-001 The block SHALL have parameter MAX_STEPS, default 64, meaning the maximum number of DDA steps per ray before reporting a miss.
REQ-002 The block SHALL have parameter T_WIDTH, default 16, meaning the width of the unsigned fixed-point tmax/tdelta values.
REQ-003 The block SHALL have port clk_in, input, 1, the single clock.
REQ-004 The block SHALL have port rst_in, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have ports start_valid (input, 1) and start_ready (output, 1): the ray-request handshake.
REQ-006 The block SHALL have ports origin (input, BlockPos), step_neg (input, 3, per-axis x/y/z direction sign, 1 = decrement), tmax_init (input, 3 x T_WIDTH) and tdelta (input, 3 x T_WIDTH).
REQ-007 The block SHALL have ports query_addr (output, BlockPos) and query_en (output, 1), which drive the chunk lookup address and read enable.
REQ-008 The block SHALL have ports query_block (input, BlockType) and query_valid (input, 1), which return the chunk lookup result.
REQ-009 The block SHALL have ports done (output, 1, one-cycle pulse), hit (output, 1), hit_pos (output, BlockPos), hit_block (output, BlockType) and hit_face (output, Face).

Function
REQ-010 FSM states: IDLE, QUERY, EVAL.
- Transitions: IDLE->QUERY on start_valid & start_ready; QUERY->EVAL on query_valid; EVAL->QUERY (step) or EVAL->IDLE (terminate).
REQ-011 start_ready SHALL be high only in IDLE; on accept, latch origin, step_neg, tmax_init and tdelta; set pos=origin and step count=0.
REQ-012 In QUERY, query_en=1 and query_addr=pos, held stable every cycle until query_valid is sampled high; query_en SHALL be 0 in IDLE and EVAL.
REQ-013 The block SHALL capture query_block only in the cycle where query_en & query_valid; query_valid at other times SHALL be ignored.
REQ-014 EVAL, hit: if the captured block != BLOCK_AIR, go to IDLE with hit=1, hit_pos=pos and hit_block=the captured block.
REQ-015 EVAL, miss at step limit: if step count == MAX_STEPS, go to IDLE with hit=0.
REQ-016 EVAL, step: otherwise select the axis with the smallest tmax (ties: x before y before z), step pos on that axis by -1 if its step_neg bit is set else +1, add tdelta to that axis's tmax, increment step count, record that axis/sign as last face, and go to QUERY.
REQ-017 tmax addition SHALL saturate at 2^T_WIDTH-1 and never wrap.
REQ-018 Out-of-bounds: if the stepped pos component is >= CHUNK_WIDTH or < -CHUNK_WIDTH, the block SHALL terminate with hit=0 without issuing a query.
REQ-019 done SHALL pulse exactly one cycle on entering IDLE from EVAL; hit, hit_pos, hit_block and hit_face SHALL hold until the next accepted start.
REQ-020 Latency SHALL be, per step, the query wait plus 2 cycles (QUERY->EVAL->QUERY).
REQ-021 If the origin block is non-air, the block SHALL report hit with zero steps and hit_face=FACE_NONE.

Reset
REQ-022 On rst_in, asynchronously: state=IDLE, start_ready=1 after release, query_en=0, query_addr=0, done=0, hit=0, hit_pos=0, hit_block=BLOCK_AIR, hit_face=FACE_NONE, step count=0.
REQ-023 A reset mid-ray SHALL abandon the ray with no done pulse.

Configuration
REQ-024 With RAYCAST_FACE_EN defined, hit_face SHALL report the face entered by the last step (FACE_NONE on a zero-step hit).
REQ-025 Without RAYCAST_FACE_EN, hit_face SHALL be constant FACE_NONE and no face tracking logic SHALL exist.

Structure
REQ-026 BlockPos, BlockType, BLOCK_AIR and CHUNK_WIDTH SHALL come from the shared types package; the new Face enum (FACE_NONE, FACE_XP, FACE_XN, FACE_YP, FACE_YN, FACE_ZP, FACE_ZN) SHALL be added there.
REQ-027 Min-of-three axis selection with tie priority SHALL be a combinational sub-module raycast_axis_select.

Verification
REQ-028 Origin (0,0,0), solid block at (3,0,0), step +x, tmax_init=(1,5,5), tdelta=(1,100,100) -> hit=1, hit_pos=(3,0,0), hit_face=FACE_XN.
REQ-029 Origin (39,0,0), step +x, all air -> done with hit=0 after 1 query, no query issued at x=40.
REQ-030 Equal tmax_init=(4,4,4), tdelta=(8,8,8) -> first step is on x, second on y, third on z.
REQ-031 All air in bounds, MAX_STEPS=4 -> exactly 5 queries, then done with hit=0.
REQ-032 Delay query_valid by 7 cycles -> query_addr stable and query_en high for all 7 cycles; a query_valid pulse while in IDLE is ignored.
REQ-033 Assert rst_in during QUERY -> query_en drops immediately, no done pulse, and the next ray behaves normally.
